// File: rtl/serial_pkg.sv
// Shared constants and helpers for the serial adder with overflow detection.
package serial_pkg;

  localparam int OVF_UNSIGNED = 0;
  localparam int OVF_SIGNED   = 1;

  function automatic int width_of(input int word_len);
    return (word_len <= 2) ? 1 : $clog2(word_len);
  endfunction

endpackage

// File: rtl/serial_fa_cell.sv
// One-bit serial full adder with its carry register; the carry is dropped at word
// boundaries (sync, abort, last bit) so no carry leaks between words.
module serial_fa_cell (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  input  logic i_sync,
  input  logic i_bit0,
  input  logic i_last,
  input  logic i_a,
  input  logic i_b,
  output logic o_sum,
  output logic o_co,
  output logic o_cin
);

  logic r_carry;
  logic w_cin;

  assign w_cin = (i_bit0 || i_sync) ? 1'b0 : r_carry;
  assign o_cin = w_cin;
  assign o_sum = i_a ^ i_b ^ w_cin;
  assign o_co  = (i_a & i_b) | (i_a & w_cin) | (i_b & w_cin);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_carry <= 1'b0;
    end else if (i_en) begin
      r_carry <= (i_last && !i_sync) ? 1'b0 : o_co;
    end else if (i_sync) begin
      r_carry <= 1'b0;
    end
  end

endmodule

// File: rtl/serial_adder_ovf.sv
// LSB-first serial adder: word framing, parallel sum readout and per-word plus
// sticky overflow reporting on top of a single full-adder cell.
module serial_adder_ovf
  import serial_pkg::*;
#(
  parameter int WORD_LEN   = 3,
  parameter int SIGNED_OVF = 0
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                en,
  input  logic                sync,
  input  logic                line1,
  input  logic                line2,
  input  logic                clr_ovf,
  output logic                outp,
  output logic                overflw,
  output logic                word_done,
  output logic [WORD_LEN-1:0] sum_word,
  output logic                ovf_sticky
);

  localparam int              CW   = width_of(WORD_LEN);
  localparam logic [CW-1:0]   LAST = CW'(WORD_LEN - 1);

  generate
    if (WORD_LEN < 2 || WORD_LEN > 32) begin : g_bad_len
      $error("serial_adder_ovf: WORD_LEN must be within 2..32");
    end
  endgenerate

  logic [CW-1:0]       r_cnt;
  logic [WORD_LEN-1:0] r_sh;
  logic [WORD_LEN-1:0] r_sum;
  logic                r_outp;
  logic                r_ovf;
  logic                r_done;
  logic                r_sticky;

  logic                w_s;
  logic                w_co;
  logic                w_cin;
  logic                w_last;
  logic                w_end;
  logic                w_ovf;
  logic [WORD_LEN-1:0] w_sh_next;

  assign w_last    = (r_cnt == LAST);
  assign w_end     = en && !sync && w_last;
  assign w_sh_next = {w_s, r_sh[WORD_LEN-1:1]};
  assign w_ovf     = (SIGNED_OVF == OVF_SIGNED) ? (w_cin ^ w_co) : w_co;

  serial_fa_cell u_fa (
    .i_clk  (clock),
    .i_rst  (reset),
    .i_en   (en),
    .i_sync (sync),
    .i_bit0 (r_cnt == '0),
    .i_last (w_last),
    .i_a    (line1),
    .i_b    (line2),
    .o_sum  (w_s),
    .o_co   (w_co),
    .o_cin  (w_cin)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt    <= '0;
      r_sh     <= '0;
      r_sum    <= '0;
      r_outp   <= 1'b0;
      r_ovf    <= 1'b0;
      r_done   <= 1'b0;
      r_sticky <= 1'b0;
    end else begin
      r_done <= w_end;
      if (en) begin
        r_outp <= w_s;
        r_sh   <= w_sh_next;
        if (sync) begin
          r_cnt <= CW'(1);
        end else if (w_last) begin
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end else if (sync) begin
        r_cnt <= '0;
      end
      if (w_end) begin
        r_sum <= w_sh_next;
        r_ovf <= w_ovf;
      end
      // A word overflow on the same edge as a clear wins.
      if (w_end && w_ovf) begin
        r_sticky <= 1'b1;
      end else if (clr_ovf) begin
        r_sticky <= 1'b0;
      end
    end
  end

  assign outp       = r_outp;
  assign overflw    = r_ovf;
  assign word_done  = r_done;
  assign sum_word   = r_sum;
  assign ovf_sticky = r_sticky;

endmodule
